cci_mpf_csr_event_ctr: RTL

Collects the single-cycle event pulses produced by the MPF shims (VTP hit/miss, page-walk busy, failed translation, VC map change, WRO conflicts, partial writes) and turns them into wide event counters for the CSR manager. A single wide adder is shared across all counters: each event has a narrow pending accumulator, and a round-robin scheduler drains one pending value per cycle into the counter array. Sits beside the CSR manager; the manager reads counters through a request/response port and can clear all counters.

---
 rtl/cci_mpf_csr_event_ctr.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cci_mpf_csr_event_ctr.sv
// Event counter bank for the MPF CSR manager: narrow per-event pending accumulators drained
// round-robin through one shared wide adder. Define CCI_MPF_CSR_EVT_OVERFLOW_EN for sticky saturation flags.
module cci_mpf_csr_event_ctr #(
  parameter int N_EVENTS   = 12,
  parameter int CNT_WIDTH  = 64,
  parameter int PEND_WIDTH = 4,
  localparam int IDX_W     = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_EVENTS-1:0]  events,
  input  logic                 rd_req_valid,
  input  logic [IDX_W-1:0]     rd_req_idx,
  output logic                 rd_req_ready,
  output logic                 rd_rsp_valid,
  output logic [CNT_WIDTH-1:0] rd_rsp_data,
  input  logic                 clr,
  output logic                 clr_busy,
  output logic [N_EVENTS-1:0]  evt_overflow
);

  typedef enum logic {ST_RUN, ST_CLEAR} state_e;

  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(N_EVENTS - 1);

  state_e                 state_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       clr_idx_q;
  logic [CNT_WIDTH-1:0]   cnt_q  [N_EVENTS];
  logic [PEND_WIDTH-1:0]  pend_q [N_EVENTS];
  logic [PEND_WIDTH-1:0]  pend_d [N_EVENTS];
  logic                   rd_rsp_valid_q;
  logic [CNT_WIDTH-1:0]   rd_rsp_data_q;

  logic                   sel_valid;
  logic [IDX_W-1:0]       sel_idx;
  logic [CNT_WIDTH-1:0]   cnt_sum;
  logic [CNT_WIDTH-1:0]   rd_peek;
  logic                   rd_accept;
  logic [N_EVENTS-1:0]    drained;

  assign rd_req_ready = (state_q == ST_RUN);
  assign clr_busy     = (state_q == ST_CLEAR);
  assign rd_rsp_valid = rd_rsp_valid_q;
  assign rd_rsp_data  = rd_rsp_data_q;
  assign rd_accept    = rd_req_valid && rd_req_ready;

  // Round-robin pick: first nonzero pending slot at or after rr_ptr_q, wrapping.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    int cand;
    cand      = 0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    if (state_q == ST_RUN) begin
      for (int off = 0; off < N_EVENTS; off++) begin
        cand = int'(rr_ptr_q) + off;
        if (cand >= N_EVENTS) cand = cand - N_EVENTS;
        if (!sel_valid && pend_q[IDX_W'(cand)] != '0) begin
          sel_valid = 1'b1;
          sel_idx   = IDX_W'(cand);
        end
      end
    end
  end

  assign cnt_sum = cnt_q[sel_idx] + CNT_WIDTH'(pend_q[sel_idx]);

  always_comb begin
    drained = '0;
    for (int i = 0; i < N_EVENTS; i++) begin
      drained[i] = sel_valid && (sel_idx == IDX_W'(i));
    end
  end

  // A drain takes the whole pending value, so the remainder is just this cycle's event.
  always_comb begin
    for (int i = 0; i < N_EVENTS; i++) begin
      pend_d[i] = drained[i] ? '0 : pend_q[i];
      if (state_q == ST_CLEAR && clr_idx_q == IDX_W'(i)) begin
        pend_d[i] = PEND_WIDTH'(events[i]);
      end else if (events[i] && pend_d[i] != PEND_MAX) begin
        pend_d[i] = pend_d[i] + PEND_WIDTH'(1);
      end
    end
  end

  // Response value must include a drain committed in the same cycle as the request.
  always_comb begin
    rd_peek = '0;
    if (int'(rd_req_idx) < N_EVENTS) begin
      if (sel_valid && sel_idx == rd_req_idx) rd_peek = cnt_sum;
      else                                    rd_peek = cnt_q[rd_req_idx];
    end
  end

  // NOTE: the counter and pending arrays are reset explicitly, since reads must return 0 after reset.
  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_RUN;
      rr_ptr_q       <= '0;
      clr_idx_q      <= '0;
      rd_rsp_valid_q <= 1'b0;
      rd_rsp_data_q  <= '0;
      for (int i = 0; i < N_EVENTS; i++) begin
        cnt_q[i]  <= '0;
        pend_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_EVENTS; i++) pend_q[i] <= pend_d[i];
      rd_rsp_valid_q <= rd_accept;
      if (rd_accept) rd_rsp_data_q <= rd_peek;
      case (state_q)
        ST_RUN: begin
          if (sel_valid) begin
            cnt_q[sel_idx] <= cnt_sum;
            rr_ptr_q       <= (sel_idx == LAST_IDX) ? '0 : sel_idx + IDX_W'(1);
          end
          if (clr) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
          end
        end
        ST_CLEAR: begin
          cnt_q[clr_idx_q] <= '0;
          if (clr_idx_q == LAST_IDX) begin
            state_q   <= ST_RUN;
            rr_ptr_q  <= '0;
            clr_idx_q <= '0;
          end else begin
            clr_idx_q <= clr_idx_q + IDX_W'(1);
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

`ifdef CCI_MPF_CSR_EVT_OVERFLOW_EN
  logic [N_EVENTS-1:0] ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < N_EVENTS; i++) begin
        if (state_q == ST_CLEAR && clr_idx_q == IDX_W'(i)) begin
          ovf_q[i] <= 1'b0;
        end else if (events[i] && !drained[i] && pend_q[i] == PEND_MAX) begin
          ovf_q[i] <= 1'b1;
        end
      end
    end
  end

  assign evt_overflow = ovf_q;
`else
  assign evt_overflow = '0;
`endif

endmodule
